// File: rtl/block_transfer_sequencer.sv
// LDM/STM block-transfer sequencer: walks a 16-bit register list, issuing one
// memory beat per register and an optional base-register writeback at the end.
module block_transfer_sequencer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              isLoad,
  input  logic              preBit,
  input  logic              upBit,
  input  logic              writeBackBit,
  input  logic [3:0]        baseReg,
  input  logic [DATA_W-1:0] baseVal,
  input  logic [15:0]       regList,
  input  logic [DATA_W-1:0] regReadData,
  output logic [3:0]        regReadAddr,
  output logic              regWriteEnable,
  output logic [3:0]        regWriteDest,
  output logic [DATA_W-1:0] regWriteData,
  output logic              memReq,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWriteData,
  input  logic [DATA_W-1:0] memReadData,
  input  logic              memAck,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    XFER      = 2'd1,
    WRITEBACK = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        list_q, list_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  final_base_q, final_base_d;
  logic [3:0]         base_reg_q, base_reg_d;
  logic               load_q, load_d;
  logic               wb_q, wb_d;

  logic [4:0]         count_c;
  logic [ADDR_W-1:0]  base_c;
  logic [ADDR_W-1:0]  span_c;
  logic [ADDR_W-1:0]  start_addr_c;
  logic [ADDR_W-1:0]  final_base_c;
  logic               base_in_list_c;
  logic [3:0]         cur_idx_c;
  logic [15:0]        list_next_c;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  // Addressing-mode arithmetic on the start-time inputs; all wraps modulo 2^ADDR_W.
  always_comb begin
    count_c = popcount16(regList);
    base_c  = ADDR_W'(baseVal);
    span_c  = ADDR_W'({count_c, 2'b00});
    case ({preBit, upBit})
      2'b01:   start_addr_c = base_c;
      2'b11:   start_addr_c = base_c + ADDR_W'(4);
      2'b00:   start_addr_c = base_c - span_c + ADDR_W'(4);
      default: start_addr_c = base_c - span_c;
    endcase
    final_base_c   = upBit ? (base_c + span_c) : (base_c - span_c);
    base_in_list_c = regList[baseReg];
    cur_idx_c      = lowest_set(list_q);
    list_next_c    = list_q & ~(16'(1) << cur_idx_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      list_q       <= '0;
      addr_q       <= '0;
      final_base_q <= '0;
      base_reg_q   <= '0;
      load_q       <= 1'b0;
      wb_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      list_q       <= list_d;
      addr_q       <= addr_d;
      final_base_q <= final_base_d;
      base_reg_q   <= base_reg_d;
      load_q       <= load_d;
      wb_q         <= wb_d;
    end
  end

  // Next state and outputs; every output idles at zero outside its own state.
  always_comb begin
    state_d        = state_q;
    list_d         = list_q;
    addr_d         = addr_q;
    final_base_d   = final_base_q;
    base_reg_d     = base_reg_q;
    load_d         = load_q;
    wb_d           = wb_q;
    regReadAddr    = '0;
    regWriteEnable = 1'b0;
    regWriteDest   = '0;
    regWriteData   = '0;
    memReq         = 1'b0;
    memWrite       = 1'b0;
    memAddr        = '0;
    memWriteData   = '0;
    busy           = 1'b0;
    done           = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          list_d       = regList;
          addr_d       = start_addr_c;
          final_base_d = final_base_c;
          base_reg_d   = baseReg;
          load_d       = isLoad;
          // A loaded base register keeps its loaded value instead of the writeback.
          wb_d         = writeBackBit && !(isLoad && base_in_list_c);
          state_d      = (regList == 16'h0000) ? DONE : XFER;
        end
      end

      XFER: begin
        busy         = 1'b1;
        memReq       = 1'b1;
        memWrite     = ~load_q;
        memAddr      = addr_q;
        regReadAddr  = cur_idx_c;
        memWriteData = regReadData;
        if (memAck) begin
          if (load_q) begin
            regWriteEnable = 1'b1;
            regWriteDest   = cur_idx_c;
            regWriteData   = memReadData;
          end
          list_d = list_next_c;
          addr_d = addr_q + ADDR_W'(4);
          if (list_next_c == 16'h0000) state_d = wb_q ? WRITEBACK : DONE;
        end
      end

      WRITEBACK: begin
        busy           = 1'b1;
        regWriteEnable = 1'b1;
        regWriteDest   = base_reg_q;
        regWriteData   = DATA_W'(final_base_q);
        state_d        = DONE;
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Directed bench for block_transfer_sequencer: a responder acks memory beats
// after a programmable wait, and a monitor scores beats and register writes.
module tb_block_transfer_sequencer;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } beat_t;

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] data;
  } rwr_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        isLoad;
  logic        preBit;
  logic        upBit;
  logic        writeBackBit;
  logic [3:0]  baseReg;
  logic [31:0] baseVal;
  logic [15:0] regList;
  logic [31:0] regReadData;
  logic [3:0]  regReadAddr;
  logic        regWriteEnable;
  logic [3:0]  regWriteDest;
  logic [31:0] regWriteData;
  logic        memReq;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;
  logic        memAck;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int ack_delay = 0;
  int wcnt = 0;

  beat_t       beat_q[$];
  rwr_t        wr_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] regs [16];

  block_transfer_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .isLoad(isLoad), .preBit(preBit),
    .upBit(upBit), .writeBackBit(writeBackBit), .baseReg(baseReg), .baseVal(baseVal),
    .regList(regList), .regReadData(regReadData), .regReadAddr(regReadAddr),
    .regWriteEnable(regWriteEnable), .regWriteDest(regWriteDest),
    .regWriteData(regWriteData), .memReq(memReq), .memWrite(memWrite),
    .memAddr(memAddr), .memWriteData(memWriteData), .memReadData(memReadData),
    .memAck(memAck), .busy(busy), .done(done)
  );

  assign regReadData = regs[regReadAddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks a pending request after ack_delay wait cycles.
  initial begin
    memAck = 1'b0;
    memReadData = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && memReq) begin
        if (wcnt >= ack_delay) begin
          memAck = 1'b1;
          memReadData = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
          wcnt = 0;
        end else begin
          memAck = 1'b0;
          wcnt++;
        end
      end else begin
        memAck = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    beat_t b;
    rwr_t  w;
    if (!reset) begin
      if (memReq && memAck) begin
        check("beat_expected", 32'(beat_q.size() != 0), 32'd1);
        if (beat_q.size() != 0) begin
          b = beat_q.pop_front();
          check("beat_addr", memAddr, b.addr);
          check("beat_write", 32'(memWrite), 32'(b.wr));
          if (b.wr) check("beat_wdata", memWriteData, b.data);
        end
      end else if (memReq && beat_q.size() != 0) begin
        check("wait_addr_stable", memAddr, beat_q[0].addr);
        if (beat_q[0].wr) check("wait_wdata_stable", memWriteData, beat_q[0].data);
      end
      if (!memReq) begin
        check("idle_addr_zero", memAddr, 32'd0);
        check("idle_wdata_zero", memWriteData, 32'd0);
      end
      if (regWriteEnable) begin
        check("rwrite_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          check("rwrite_dest", 32'(regWriteDest), 32'(w.dest));
          check("rwrite_data", regWriteData, w.data);
        end
      end
    end
  end

  task automatic push_beat(input logic [31:0] a, input logic wr, input logic [31:0] d);
    beat_t b;
    b.addr = a; b.wr = wr; b.data = d;
    beat_q.push_back(b);
  endtask

  task automatic push_wr(input logic [3:0] dst, input logic [31:0] d);
    rwr_t w;
    w.dest = dst; w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic do_start(input logic ld, input logic p, input logic u, input logic wb,
                          input logic [3:0] br, input logic [31:0] base, input logic [15:0] list);
    @(negedge clk);
    isLoad = ld; preBit = p; upBit = u; writeBackBit = wb;
    baseReg = br; baseVal = base; regList = list;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_cyc, input string tag);
    int cyc;
    bit seen;
    cyc = 0;
    seen = 1'b0;
    while (cyc < 60 && !seen) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_memreq_at_done"}, 32'(memReq), 32'd0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_beats_left"}, 32'(beat_q.size()), 32'd0);
    check({tag, "_writes_left"}, 32'(wr_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; isLoad = 1'b0; preBit = 1'b0; upBit = 1'b0; writeBackBit = 1'b0;
    baseReg = '0; baseVal = '0; regList = '0;
    for (int i = 0; i < 16; i++) regs[i] = 32'h100 + 32'(i);
    regs[1] = 32'h11;
    regs[2] = 32'h22;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_memreq", 32'(memReq), 32'd0);
    check("rst_rwe", 32'(regWriteEnable), 32'd0);
    check("rst_memaddr", memAddr, 32'd0);
    reset = 1'b0;

    // STM IA with writeback
    ack_delay = 0;
    push_beat(32'h1000, 1'b1, 32'h11);
    push_beat(32'h1004, 1'b1, 32'h22);
    push_wr(4'd5, 32'h1008);
    do_start(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 32'h1000, 16'h0006);
    wait_done(4, "stm_ia");

    // LDM DB including R15, no writeback
    push_beat(32'h1FF8, 1'b0, 32'h0);
    push_beat(32'h1FFC, 1'b0, 32'h0);
    push_wr(4'd0, 32'hA);
    push_wr(4'd15, 32'hB);
    rd_q.push_back(32'hA);
    rd_q.push_back(32'hB);
    do_start(1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 32'h2000, 16'h8001);
    wait_done(3, "ldm_db");

    // LDM IB with base in list: loaded value wins, writeback skipped
    push_beat(32'h3004, 1'b0, 32'h0);
    push_wr(4'd3, 32'h55);
    rd_q.push_back(32'h55);
    do_start(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 32'h3000, 16'h0008);
    wait_done(2, "ldm_ib_base");

    // STM DA with base in list stores the original base value
    regs[0] = 32'h5000;
    push_beat(32'h4FFC, 1'b1, 32'h5000);
    push_beat(32'h5000, 1'b1, 32'h11);
    push_wr(4'd0, 32'h4FF8);
    do_start(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h5000, 16'h0003);
    wait_done(4, "stm_da_base");

    // LDM IA with 3 wait states per beat, writeback
    ack_delay = 3;
    push_beat(32'h4000, 1'b0, 32'h0);
    push_beat(32'h4004, 1'b0, 32'h0);
    push_wr(4'd4, 32'h77);
    push_wr(4'd5, 32'h88);
    push_wr(4'd1, 32'h4008);
    rd_q.push_back(32'h77);
    rd_q.push_back(32'h88);
    do_start(1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 32'h4000, 16'h0030);
    wait_done(10, "ldm_wait");

    // Empty list: straight to DONE
    ack_delay = 0;
    do_start(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 32'h9000, 16'h0000);
    wait_done(1, "empty");

    // start pulsed while busy is ignored
    ack_delay = 2;
    push_beat(32'h6000, 1'b0, 32'h0);
    push_wr(4'd2, 32'h99);
    rd_q.push_back(32'h99);
    do_start(1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 32'h6000, 16'h0004);
    @(negedge clk);
    check("busy_in_xfer", 32'(busy), 32'd1);
    isLoad = 1'b0; regList = 16'hFFFF; writeBackBit = 1'b1; baseVal = 32'hAAAA_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(3, "busy_start");

    // Reset in the middle of a 4-beat LDM after the first beat
    ack_delay = 1;
    push_beat(32'h7000, 1'b0, 32'h0);
    push_wr(4'd0, 32'h1);
    for (int i = 1; i <= 4; i++) rd_q.push_back(32'(i));
    do_start(1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 32'h7000, 16'h000F);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_memreq", 32'(memReq), 32'd0);
    check("midrst_rwe", 32'(regWriteEnable), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_memaddr", memAddr, 32'd0);
    check("midrst_beats_left", 32'(beat_q.size()), 32'd0);
    check("midrst_writes_left", 32'(wr_q.size()), 32'd0);
    rd_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("postrst_idle", 32'(busy), 32'd0);

    // Normal STM after the aborted transfer
    ack_delay = 0;
    regs[0] = 32'h0BAD_0000;
    push_beat(32'h8000, 1'b1, 32'h0BAD_0000);
    do_start(1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 32'h8000, 16'h0001);
    wait_done(2, "postrst_stm");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/block_transfer_sequencer.md
Name: block_transfer_sequencer

Overview:
- Sequences ARM LDM/STM block transfers. It walks a 16-bit register list, driving the register file's read address (STM) or its write port (LDM) one register per memory beat.
- Issues word addresses to data memory through a req/ack handshake and performs the optional base-register writeback.
- Sits between decode and the register file/data-memory path, and owns the register-file write port while busy.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, data/register width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a transfer; ignored while busy.
- isLoad  input  1  1 = LDM, 0 = STM.
- preBit  input  1  P bit: increment/decrement before each access.
- upBit  input  1  U bit: ascending base (1) or descending base (0).
- writeBackBit  input  1  W bit: update the base register at the end.
- baseReg  input  4  base register index.
- baseVal  input  32  base register value, sampled at start.
- regList  input  16  register list, sampled at start.
- regReadData  input  32  register file read data for regReadAddr.
- regReadAddr  output  4  register index presented to the register file read port.
- regWriteEnable  output  1  register file write strobe.
- regWriteDest  output  4  register file write destination.
- regWriteData  output  32  register file write data.
- memReq  output  1  memory request, held high until acknowledged.
- memWrite  output  1  1 = store beat.
- memAddr  output  32  word address of the current beat.
- memWriteData  output  32  store data.
- memReadData  input  32  load data, valid together with memAck.
- memAck  input  1  beat complete.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset, asynchronous: state=IDLE. All outputs 0, including busy, done, memReq and regWriteEnable. Reset mid-transfer aborts the transfer with no further writes.
- States: IDLE, XFER, WRITEBACK, DONE.
- IDLE: on start, latch regList, baseVal, baseReg and the P/U/W/isLoad bits. Compute n = popcount(regList).
- Start address, all modulo 2^32:
  - IA (P=0,U=1): base
  - IB (P=1,U=1): base+4
  - DA (P=0,U=0): base-4n+4
  - DB (P=1,U=0): base-4n
- Final base: U ? base+4n : base-4n.
- Transition out of IDLE: n=0 goes to DONE (no memory beats, no writeback). Otherwise go to XFER with current = lowest set bit.
- Ordering: registers are transferred lowest index first at the lowest address, and the address always ascends by 4 per beat.
- XFER:
  - memReq=1, memAddr=current address, memWrite=~isLoad.
  - regReadAddr=current index; memWriteData=regReadData (combinational).
  - memReq stays high and address/data stay stable until memAck.
- On memAck in XFER:
  - LDM: in the same cycle, regWriteEnable=1, regWriteDest=current index, regWriteData=memReadData.
  - Clear the current bit and advance to the next set bit with address+4 on the next cycle.
  - With one ack per cycle the block sustains one register per cycle.
- After the final ack:
  - Go to WRITEBACK if W=1 and not (isLoad and baseReg is in the list); otherwise go to DONE.
  - For LDM with the base in the list, the loaded value wins.
  - STM with the base in the list stores the original base value.
- WRITEBACK: one cycle with regWriteEnable=1, regWriteDest=baseReg, regWriteData=final base. memReq=0.
- DONE: done=1 and busy=0 for one cycle, then IDLE. start is accepted in the cycle following DONE.
- R15 in an LDM list writes dest 15; the register file flags the PC write. The sequencer gives it no special handling.
- memAck outside XFER is ignored. memAddr and memWriteData are 0 whenever memReq=0.
- Minimum latency: start at cycle 0, first memReq at cycle 1. With immediate acks, done = cycle n+1 without writeback, or n+2 with writeback.

Test Plan:
- STM IA, base=0x1000, list=0x0006 (R1=0x11, R2=0x22), W=1, ack immediate -> beats at 0x1000/0x11 and 0x1004/0x22; WRITEBACK R(base)=0x1008; done at cycle 4.
- LDM DB, base=0x2000, list=0x8001, memReadData 0xA then 0xB, W=0 -> addrs 0x1FF8, 0x1FFC; writes R0=0xA then R15=0xB; no writeback.
- LDM IB with baseReg=R3, list=0x0008, W=1, read 0x55 -> addr base+4; R3=0x55 only; WRITEBACK skipped.
- Wait states: memAck delayed 3 cycles per beat -> memReq and memAddr stay stable through the waits; exactly one regWriteEnable per LDM ack.
- Empty list -> no memReq, done pulse the cycle after DONE entry; start pulsed while busy has no effect.
- Reset asserted mid-XFER after the first of 4 beats -> outputs 0 immediately; no further writes; a new start afterwards runs normally from IDLE.
